op_downscale: RTL and testbench
===============================

// Module: op_downscale
// PURPOSE
//  Output-side counterpart of the input upscaler: converts CORDIC-width signed x/y results
//  back to DATA_WIDTH samples.
//  - Rounds away the CORDIC_WIDTH-DATA_WIDTH guard LSBs (round-half-up, or truncate).
//  - Saturates to the signed DATA_WIDTH range.
//  - Two-stage pipeline with valid/ready backpressure.
//  - Counts saturation events for the ICA control path.
//  Sits between the CORDIC core output and the sample writer.
// PARAMETERS
//  DATA_WIDTH   16  output sample width (signed two's complement)
//  CORDIC_WIDTH 22  input width; must be > DATA_WIDTH; SHIFT = CORDIC_WIDTH-DATA_WIDTH
//  ROUND        1   1 = round-half-up (add 2^(SHIFT-1) before shift); 0 = truncate (floor)
//  COUNT_W      16  width of saturation event counter
// PORTS
//  clk        in   1             clock, all state on rising edge
//  rst        in   1             asynchronous, active-high reset
//  x_in       in   CORDIC_WIDTH  signed x from CORDIC
//  y_in       in   CORDIC_WIDTH  signed y from CORDIC
//  in_valid   in   1             x_in/y_in valid
//  in_ready   out  1             block can accept this cycle
//  x_out      out  DATA_WIDTH    rounded/saturated x
//  y_out      out  DATA_WIDTH    rounded/saturated y
//  out_valid  out  1             x_out/y_out/sat_out valid
//  out_ready  in   1             downstream accepts this cycle
//  sat_out    out  1             this output sample saturated in x or y
//  sat_clr    in   1             synchronous clear of sat_count
//  sat_count  out  COUNT_W       number of saturated samples handed off, sticky at max
// BEHAVIOUR
//  - Reset: all outputs 0; both stage valids 0; in_ready therefore 1 after reset.
//  - Transfer: in on in_valid&&in_ready; out on out_valid&&out_ready.
//  - Pipeline enables:
//    - s2_en = !out_valid || out_ready.
//    - s1_en = !s1_valid || s2_en.
//    - in_ready = s1_en (combinational from out_ready; no bubble).
//  - Latency 2 cycles from input transfer to out_valid; throughput 1 sample/clk.
//  - Stalled output holds x_out/y_out/sat_out/out_valid stable until accepted.
//  - Stage 1 (per axis):
//    - s = sext(v_in, CORDIC_WIDTH+1) + (ROUND ? 2^(SHIFT-1) : 0).
//    - Registered when s1_en; s1_valid <= in_valid.
//  - Stage 2 (per axis):
//    - q = s >>> SHIFT (DATA_WIDTH+1 bits, arithmetic).
//    - q > 2^(DW-1)-1 -> 2^(DW-1)-1, sat.
//    - q < -2^(DW-1) -> -2^(DW-1), sat.
//    - Else q[DW-1:0].
//    - sat_out = sat_x | sat_y.
//    - Registered when s2_en; out_valid <= s1_valid.
//  - Round-trip: the upscaler output (x<<SHIFT) downscales to exactly x, never saturating.
//  - sat_count: +1 on each output transfer with sat_out=1; holds at 2^COUNT_W-1.
//    - sat_clr has priority: same-cycle event is dropped and count becomes 0.
//  - Reset mid-operation discards in-flight samples; no output transfer may follow until new input.
// TESTING
//  (DW=16, CW=22, ROUND=1, SHIFT=6; values hex)
//  1. Values, out_ready=1:
//     - x_in=000040 -> x_out=0001.
//     - x_in=00005F -> 0001.
//     - x_in=000060 -> 0002.
//     - x_in=3FFFE0 (-32) -> 0000.
//     - x_in=3FFFC0 -> FFFF.
//     - sat_out=0, 2 cycles latency each.
//  2. Saturation:
//     - x_in=1FFFFF -> x_out=7FFF, sat_out=1.
//     - y_in=200000 -> y_out=8000, sat_out=0.
//     - sat_count +1 only on handoff.
//  3. Backpressure:
//     - Stream 8 samples, out_ready low cycles 3-6.
//     - in_ready drops after 2 buffered; no loss, duplication or reorder.
//     - Outputs stable while stalled.
//  4. Round-trip: random 16-bit x, y, input {x,6'b0} -> out x; sat_out=0 for 10k samples.
//  5. Counter: COUNT_W=3, 9 saturating samples -> sat_count=7 sticky.
//     - sat_clr with simultaneous saturating handoff -> 0.
//  6. Reset: assert rst with samples in both stages -> out_valid=0, sat_count=0 immediately.
//     - Next output only 2 clks after new input.

Source files
------------

// File: rtl/op_downscale.sv
// op_downscale: brings CORDIC-width signed x/y results back to DATA_WIDTH samples.
// Stage 1 sign-extends and adds the rounding offset. Stage 2 drops the guard LSBs and
// saturates to the signed output range. A valid/ready handshake lets the output stall,
// and saturated samples that are handed off are counted for the ICA control path.
module op_downscale #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned CORDIC_WIDTH = 22,
    parameter int unsigned ROUND        = 1,
    parameter int unsigned COUNT_W      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [CORDIC_WIDTH-1:0] x_in,
    input  logic [CORDIC_WIDTH-1:0] y_in,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [DATA_WIDTH-1:0]   x_out,
    output logic [DATA_WIDTH-1:0]   y_out,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sat_out,
    input  logic                    sat_clr,
    output logic [COUNT_W-1:0]      sat_count
);

    localparam int unsigned SHIFT = CORDIC_WIDTH - DATA_WIDTH;
    // One extra bit so the rounding add can never wrap.
    localparam int unsigned SUM_W = CORDIC_WIDTH + 1;
    localparam logic [SUM_W-1:0] RoundAdd =
        (ROUND != 0) ? (SUM_W'(1) << (SHIFT - 1)) : '0;

    // Stage 1 state
    logic                  s1_valid_q;
    logic [SUM_W-1:0]      s1_x_q, s1_x_d;
    logic [SUM_W-1:0]      s1_y_q, s1_y_d;

    // Stage 2 (output) state
    logic                  out_valid_q;
    logic [DATA_WIDTH-1:0] x_out_q, x_out_d;
    logic [DATA_WIDTH-1:0] y_out_q, y_out_d;
    logic                  sat_q, sat_d;

    // Saturation counter
    logic [COUNT_W-1:0]    sat_count_q, sat_count_d;

    // Pipeline control
    logic s1_en, s2_en;
    logic out_fire;

    // Stage 2 intermediates: the arithmetic shift is just the upper DATA_WIDTH+1 bits.
    logic [DATA_WIDTH:0]   qx, qy;
    logic                  sat_x, sat_y;

    // The guard LSBs only exist to carry the rounding offset into the kept bits.
    logic                  unused_lsbs;
    assign unused_lsbs = ^{s1_x_q[SHIFT-1:0], s1_y_q[SHIFT-1:0]};

    // Handshake: stage 2 moves when its slot is empty or being drained, stage 1 likewise.
    always_comb begin
        s2_en    = !out_valid_q || out_ready;
        s1_en    = !s1_valid_q || s2_en;
        in_ready = s1_en;
        out_fire = out_valid_q && out_ready;
    end

    // Stage 1 next state: sign-extend by one bit and add half an output LSB.
    always_comb begin
        s1_x_d = {x_in[CORDIC_WIDTH-1], x_in} + RoundAdd;
        s1_y_d = {y_in[CORDIC_WIDTH-1], y_in} + RoundAdd;
    end

    // Stage 1 registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
        end else if (s1_en) begin
            s1_valid_q <= in_valid;
            s1_x_q     <= s1_x_d;
            s1_y_q     <= s1_y_d;
        end
    end

    // Stage 2 next state: floor-shift, then clamp when the top two bits disagree.
    always_comb begin
        qx    = s1_x_q[SUM_W-1:SHIFT];
        qy    = s1_y_q[SUM_W-1:SHIFT];
        sat_x = qx[DATA_WIDTH] ^ qx[DATA_WIDTH-1];
        sat_y = qy[DATA_WIDTH] ^ qy[DATA_WIDTH-1];

        x_out_d = qx[DATA_WIDTH-1:0];
        if (sat_x) begin
            // Positive overflow -> 0111..1, negative overflow -> 1000..0
            x_out_d = {qx[DATA_WIDTH], {(DATA_WIDTH - 1){~qx[DATA_WIDTH]}}};
        end

        y_out_d = qy[DATA_WIDTH-1:0];
        if (sat_y) begin
            y_out_d = {qy[DATA_WIDTH], {(DATA_WIDTH - 1){~qy[DATA_WIDTH]}}};
        end

        sat_d = sat_x | sat_y;
    end

    // Stage 2 registers: held stable while the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            x_out_q     <= '0;
            y_out_q     <= '0;
            sat_q       <= 1'b0;
        end else if (s2_en) begin
            out_valid_q <= s1_valid_q;
            x_out_q     <= x_out_d;
            y_out_q     <= y_out_d;
            sat_q       <= sat_d;
        end
    end

    // Counter next state: clear wins over a same-cycle event; stick at all-ones.
    always_comb begin
        sat_count_d = sat_count_q;
        if (sat_clr) begin
            sat_count_d = '0;
        end else if (out_fire && sat_q && (sat_count_q != '1)) begin
            sat_count_d = sat_count_q + 1'b1;
        end
    end

    // Saturation event counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count_q <= '0;
        end else begin
            sat_count_q <= sat_count_d;
        end
    end

    assign x_out     = x_out_q;
    assign y_out     = y_out_q;
    assign out_valid = out_valid_q;
    assign sat_out   = sat_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_op_downscale.sv
// Directed bench for op_downscale: value table, saturation, backpressure, round-trip,
// sticky counter (second instance with a 3-bit counter) and mid-stream reset.
module tb_op_downscale;

    logic        clk = 1'b0;
    logic        rst;
    logic [21:0] x_in, y_in;
    logic        in_valid, out_ready, sat_clr;
    logic        in_ready, out_valid, sat_out;
    logic [15:0] x_out, y_out, sat_count;
    logic        in_ready3, out_valid3, sat_out3;
    logic [15:0] x_out3, y_out3;
    logic [2:0]  sat_count3;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    op_downscale u_dut (
        .clk       (clk),
        .rst       (rst),
        .x_in      (x_in),
        .y_in      (y_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_out     (x_out),
        .y_out     (y_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat_out   (sat_out),
        .sat_clr   (sat_clr),
        .sat_count (sat_count)
    );

    op_downscale #(.COUNT_W(3)) u_dut3 (
        .clk       (clk),
        .rst       (rst),
        .x_in      (x_in),
        .y_in      (y_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready3),
        .x_out     (x_out3),
        .y_out     (y_out3),
        .out_valid (out_valid3),
        .out_ready (out_ready),
        .sat_out   (sat_out3),
        .sat_clr   (sat_clr),
        .sat_count (sat_count3)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [21:0] x;
        logic [21:0] y;
        logic [15:0] ex;
        logic [15:0] ey;
        logic        esat;
    } vec_t;

    typedef struct {
        logic [15:0] x;
        logic [15:0] y;
    } exp_t;

    vec_t vecs[10];

    // One isolated sample through the pipe, checking the two-cycle latency.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        x_in = v.x; y_in = v.y; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        chk($sformatf("lat1_%0d", idx), 64'(out_valid), 64'd0);
        @(negedge clk);
        chk($sformatf("vec_%0d", idx), {out_valid, x_out, y_out, sat_out},
            {1'b1, v.ex, v.ey, v.esat});
    endtask

    initial begin
        exp_t q[$];
        exp_t e;
        int   sent, rcvd, occ, in_f, out_f;
        logic prev_stall;
        logic [15:0] prev_x, prev_y;
        logic [15:0] r16x, r16y;

        vecs[0] = '{22'h000040, 22'h000000, 16'h0001, 16'h0000, 1'b0};
        vecs[1] = '{22'h00005F, 22'h000020, 16'h0001, 16'h0001, 1'b0};
        vecs[2] = '{22'h000060, 22'h00001F, 16'h0002, 16'h0000, 1'b0};
        vecs[3] = '{22'h3FFFE0, 22'h3FFFC0, 16'h0000, 16'hFFFF, 1'b0};
        vecs[4] = '{22'h3FFFC0, 22'h3FFFDF, 16'hFFFF, 16'hFFFF, 1'b0};
        vecs[5] = '{22'h1FFFFF, 22'h200000, 16'h7FFF, 16'h8000, 1'b1};
        vecs[6] = '{22'h000000, 22'h200000, 16'h0000, 16'h8000, 1'b0};
        vecs[7] = '{22'h1FFFC0, 22'h1FFFE0, 16'h7FFF, 16'h7FFF, 1'b1};
        vecs[8] = '{22'h3FFFFF, 22'h200020, 16'h0000, 16'h8001, 1'b0};
        vecs[9] = '{22'h00FFDF, 22'h3F0021, 16'h03FF, 16'hFC01, 1'b0};

        rst = 1'b1; x_in = '0; y_in = '0; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_state", {out_valid, x_out, y_out, sat_out, sat_count, in_ready},
            {1'b0, 16'h0, 16'h0, 1'b0, 16'h0, 1'b1});
        rst = 1'b0;

        // ---- value table ----
        for (int i = 0; i < 10; i++) apply(vecs[i], i);
        @(negedge clk);
        chk("sat_count_table", 64'(sat_count), 64'd2);

        // ---- count only on handoff ----
        x_in = 22'h1FFFFF; y_in = 22'h0; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("stall_hold_valid", {out_valid, sat_out}, {1'b1, 1'b1});
        chk("no_count_before_handoff", 64'(sat_count), 64'd2);
        repeat (3) @(negedge clk);
        chk("stall_still_held", {out_valid, x_out, sat_count}, {1'b1, 16'h7FFF, 16'd2});
        out_ready = 1'b1;
        @(negedge clk);
        chk("count_on_handoff", {out_valid, sat_count}, {1'b0, 16'd3});

        // ---- backpressure: 8 samples, out_ready low cycles 3..6 ----
        sent = 0; rcvd = 0; occ = 0; prev_stall = 1'b0; prev_x = '0; prev_y = '0;
        for (int cyc = 0; cyc < 40 && rcvd < 8; cyc++) begin
            out_ready = !(cyc >= 3 && cyc <= 6);
            in_valid  = (sent < 8);
            x_in      = 22'(sent + 1) << 6;
            y_in      = 22'(-(sent + 1)) << 6;
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'((occ < 2) || out_ready));
            if (prev_stall)
                chk("bp_stable", {out_valid, x_out, y_out}, {1'b1, prev_x, prev_y});
            in_f  = int'(in_valid && in_ready);
            out_f = int'(out_valid && out_ready);
            if (out_f == 1) begin
                chk("bp_data", {x_out, y_out}, {16'(rcvd + 1), 16'(-(rcvd + 1))});
                rcvd++;
            end
            prev_stall = out_valid && !out_ready;
            prev_x = x_out; prev_y = y_out;
            sent += in_f;
            occ  = occ + in_f - out_f;
            @(negedge clk);
        end
        in_valid = 1'b0; out_ready = 1'b1;
        chk("bp_count", {32'(sent), 32'(rcvd)}, {32'd8, 32'd8});
        repeat (3) @(negedge clk);
        chk("bp_no_dup", 64'(out_valid), 64'd0);

        // ---- round-trip: {x,6'b0} -> x, never saturating ----
        sent = 0; rcvd = 0;
        for (int cyc = 0; cyc < 10100 && rcvd < 10000; cyc++) begin
            if (out_valid) begin
                if (q.size() == 0) begin
                    chk("rt_spurious", 64'(out_valid), 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("rt_sample", {x_out, y_out, sat_out}, {e.x, e.y, 1'b0});
                    rcvd++;
                end
            end
            r16x = 16'($urandom_range(0, 65535));
            r16y = 16'($urandom_range(0, 65535));
            in_valid = (sent < 10000);
            x_in = {r16x, 6'b0};
            y_in = {r16y, 6'b0};
            #1;
            if (in_valid && in_ready) begin
                q.push_back('{r16x, r16y});
                sent++;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        chk("rt_count", 64'(rcvd), 64'd10000);

        // ---- sticky counter on the 3-bit instance ----
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        chk("clr_zero", {sat_count, 13'd0, sat_count3}, {16'd0, 16'd0});
        x_in = 22'h1FFFFF; y_in = 22'h200000; in_valid = 1'b1;
        repeat (9) @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("sticky_3bit", 64'(sat_count3), 64'd7);
        chk("count_16bit", 64'(sat_count), 64'd9);
        apply('{22'h200000, 22'h1FFFFF, 16'h8000, 16'h7FFF, 1'b1}, 99);
        @(negedge clk);
        chk("sticky_stays", {sat_count, 13'd0, sat_count3}, {16'd10, 16'd7});

        // clear coinciding with a saturating handoff: clear wins
        x_in = 22'h1FFFFF; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("clr_setup", {out_valid, sat_out}, {1'b1, 1'b1});
        out_ready = 1'b1; sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        chk("clr_priority", {out_valid, sat_count, 13'd0, sat_count3}, {1'b0, 16'd0, 16'd0});

        // ---- reset with both stages full ----
        apply(vecs[5], 100);
        @(negedge clk);
        chk("pre_rst_count", 64'(sat_count), 64'd1);
        x_in = 22'h000040; y_in = 22'h000040; in_valid = 1'b1; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        chk("both_full", {out_valid, in_ready}, {1'b1, 1'b0});
        #1 rst = 1'b1;
        #1;
        chk("rst_immediate", {out_valid, sat_count, x_out, in_ready},
            {1'b0, 16'd0, 16'd0, 1'b1});
        @(negedge clk);
        rst = 1'b0; out_ready = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_no_ghost", 64'(out_valid), 64'd0);
        end
        apply(vecs[2], 101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
